axi_4_lite_arb_mst: RTL

Two-port round-robin arbiter and AXI4-Lite master. It shares a single AXI4-Lite slave register file (axi_4_slv) between two internal requesters, for example a CPU-side bridge and a DMA/config sequencer. Each requester issues simple single-word read/write commands. The block serializes them into AXI4-Lite transactions, with one outstanding transaction at a time, and returns the response to the owning requester.

---
 rtl/axi_4_lite_arb_mst_if.sv | 51 +++++
 rtl/axi_4_lite_arb_mst.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/axi_4_lite_arb_mst_if.sv
// AXI4-Lite bus between the two-port arbiter master and a single register-file slave.
// The master modport drives the request channels; the slave modport is the mirror view.
interface axi_4_lite_arb_mst_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]            M_AXI_AWPROT;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [STRB_WIDTH-1:0] M_AXI_WSTRB;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]            M_AXI_ARPROT;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;

  modport master (
    output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_BREADY,
    output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    output M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY,
    input  M_AXI_BVALID, M_AXI_BRESP,
    input  M_AXI_ARREADY,
    input  M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );

  modport slave (
    input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_BREADY,
    input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    input  M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY,
    output M_AXI_BVALID, M_AXI_BRESP,
    output M_AXI_ARREADY,
    output M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );
endinterface

// File: rtl/axi_4_lite_arb_mst.sv
// Two-requester arbiter serialising single-word commands onto one AXI4-Lite master, one outstanding; ~4-5 cycles/txn vs zero-wait slave.
// Commands wait (reqN_ready low) outside IDLE; responses are a one-cycle pulse with no back-pressure. Define AXI_ARB_FIXED_PRIO_EN for fixed req0 priority.
module axi_4_lite_arb_mst #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [STRB_WIDTH-1:0] req0_wstrb,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic [1:0]            rsp0_resp,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [STRB_WIDTH-1:0] req1_wstrb,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [1:0]            rsp1_resp,

  axi_4_lite_arb_mst_if.master  m_axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic                  gnt_vld;
  logic                  gnt_id;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;

  logic                  grant_id;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_hs;
  logic                  w_hs;

`ifdef AXI_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_id  = ~req0_valid;
  end
`else
  logic last_grant;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = ~req0_valid;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      last_grant <= 1'b1;
    end else if (state == RESP) begin
      last_grant <= grant_id;
    end
  end
`endif

  assign accept    = (state == IDLE) && gnt_vld && S_AXI_ARESETN;
  assign sel_we    = gnt_id ? req1_we    : req0_we;
  assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
  assign sel_wdata = gnt_id ? req1_wdata : req0_wdata;
  assign sel_wstrb = gnt_id ? req1_wstrb : req0_wstrb;

  assign aw_hs = m_axi.M_AXI_AWVALID && m_axi.M_AXI_AWREADY;
  assign w_hs  = m_axi.M_AXI_WVALID  && m_axi.M_AXI_WREADY;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = sel_we ? WR : RD_ADDR;
      // AW and W may complete in different cycles; leave only when both have.
      WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (m_axi.M_AXI_BVALID) state_nxt = RESP;
      RD_ADDR: if (m_axi.M_AXI_ARREADY) state_nxt = RD_DATA;
      RD_DATA: if (m_axi.M_AXI_RVALID) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      grant_id <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= 2'b00;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      if (accept) begin
        grant_id <= gnt_id;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        wstrb_q  <= sel_wstrb;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end
      if (state == WR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if ((state == WR_RESP) && m_axi.M_AXI_BVALID) begin
        rdata_q <= '0;
        resp_q  <= m_axi.M_AXI_BRESP;
      end
      if ((state == RD_DATA) && m_axi.M_AXI_RVALID) begin
        rdata_q <= m_axi.M_AXI_RDATA;
        resp_q  <= m_axi.M_AXI_RRESP;
      end
    end
  end

  always_comb begin
    m_axi.M_AXI_AWVALID = 1'b0;
    m_axi.M_AXI_WVALID  = 1'b0;
    m_axi.M_AXI_BREADY  = 1'b0;
    m_axi.M_AXI_ARVALID = 1'b0;
    m_axi.M_AXI_RREADY  = 1'b0;
    req0_ready          = 1'b0;
    req1_ready          = 1'b0;
    rsp0_valid          = 1'b0;
    rsp1_valid          = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = accept && !gnt_id;
        req1_ready = accept &&  gnt_id;
      end
      WR: begin
        m_axi.M_AXI_AWVALID = !aw_done;
        m_axi.M_AXI_WVALID  = !w_done;
      end
      WR_RESP: m_axi.M_AXI_BREADY  = 1'b1;
      RD_ADDR: m_axi.M_AXI_ARVALID = 1'b1;
      RD_DATA: m_axi.M_AXI_RREADY  = 1'b1;
      RESP: begin
        rsp0_valid = !grant_id;
        rsp1_valid =  grant_id;
      end
      default: ;
    endcase
  end

  assign m_axi.M_AXI_AWADDR = addr_q;
  assign m_axi.M_AXI_ARADDR = addr_q;
  assign m_axi.M_AXI_AWPROT = 3'b000;
  assign m_axi.M_AXI_ARPROT = 3'b000;
  assign m_axi.M_AXI_WDATA  = wdata_q;
  assign m_axi.M_AXI_WSTRB  = wstrb_q;

  assign rsp0_rdata = rdata_q;
  assign rsp0_resp  = resp_q;
  assign rsp1_rdata = rdata_q;
  assign rsp1_resp  = resp_q;

endmodule
